channel_mux: RTL and testbench
==============================

CHANNEL_MUX -- requirements
Module: channel_mux

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 4, bits per channel sample.
REQ-002 SHALL have parameter SEL_WIDTH, 3, width of channel index.
REQ-003 SHALL have parameter INPUT_WIDTH, 5, number of input channels; INPUT_WIDTH <= 2**SEL_WIDTH and INPUT_WIDTH >= 2.
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port data_i  input  DATA_WIDTH x INPUT_WIDTH (unpacked array)  per-channel sample.
REQ-007 SHALL have port valid_i  input  INPUT_WIDTH  per-channel request; bit k qualifies data_i[k].
REQ-008 SHALL have port ready_o  output  INPUT_WIDTH  per-channel accept; at most one bit set per cycle.
REQ-009 SHALL have port data_o  output  DATA_WIDTH  registered merged sample.
REQ-010 SHALL have port sel_o  output  SEL_WIDTH  registered index of channel that sourced data_o.
REQ-011 SHALL have port valid_o  output  1  data_o/sel_o hold a beat.
REQ-012 SHALL have port ready_i  input  1  downstream accepts beat when valid_o && ready_i.

Function
REQ-013 SHALL hold one output beat register (data_o, sel_o, valid_o) and a round-robin pointer ptr, range 0..INPUT_WIDTH-1.
REQ-014 SHALL define out_free = !valid_o || ready_i (combinational).
REQ-015 SHALL, when out_free and any valid_i bit set, grant channel g = first k with valid_i[k]=1 searching ptr, ptr+1, ..., wrapping INPUT_WIDTH-1 -> 0.
REQ-016 SHALL drive ready_o = one-hot(g) in a granting cycle and all-zero otherwise; ready_o may depend combinationally on valid_i and ready_i.
REQ-017 SHALL treat channel k transfer as valid_i[k] && ready_o[k]; on transfer, next cycle data_o = data_i[g], sel_o = g, valid_o = 1 (latency 1 cycle).
REQ-018 SHALL, on grant of g, set ptr <= g+1, with g = INPUT_WIDTH-1 wrapping to 0 (not to 2**SEL_WIDTH).
REQ-019 SHALL, when out_free and no valid_i set, clear valid_o next cycle if a beat was consumed; data_o/sel_o hold last values; ptr unchanged.
REQ-020 SHALL, when valid_o && !ready_i, hold data_o, sel_o, valid_o stable and drive ready_o = 0.
REQ-021 SHALL sustain one beat per cycle when ready_i held 1 and requests present (simultaneous consume and load in the same cycle).
REQ-022 SHALL ignore data_i[k] for unrequested channels; channel sources keep valid_i[k]/data_i[k] stable until accepted.
REQ-023 SHALL never emit sel_o >= INPUT_WIDTH.

Reset
REQ-024 SHALL, on a clock edge with rst_i=1, set valid_o=0, data_o=0, sel_o=0, ptr=0.
REQ-025 SHALL drive ready_o = 0 in any cycle where rst_i=1, regardless of valid_i; no transfer occurs.
REQ-026 SHALL, on reset mid-operation, discard any held beat (no replay); first post-reset grant searches from channel 0.

Verification
REQ-027 SHALL verify single request: after reset, valid_i=5'b00100, data_i[2]=4'b1010, ready_i=1 -> ready_o=5'b00100 that cycle; next cycle valid_o=1, data_o=4'b1010, sel_o=3'b010; ptr=3.
REQ-028 SHALL verify fairness: valid_i=5'b11111 held, ready_i=1, distinct data per channel -> sel_o sequence 0,1,2,3,4,0 on consecutive cycles, valid_o continuously 1.
REQ-029 SHALL verify backpressure: valid_o=1, sel_o=1, ready_i=0 for 3 cycles with valid_i=5'b00011 -> data_o/sel_o stable, ready_o=0; ready_i=1 -> that cycle ready_o=5'b00001 (ptr=2 wraps past 2,3,4), next cycle sel_o=0.
REQ-030 SHALL verify wrap: after grant of channel 3 (ptr=4), valid_i=5'b00011 -> grant channel 0, then channel 1.
REQ-031 SHALL verify reset mid-operation: valid_o=1, sel_o=3, ptr=4, rst_i=1 one cycle with valid_i=5'b11111 -> ready_o=0 during reset, then valid_o=0, data_o=0, sel_o=0; next grant channel 0.
REQ-032 SHALL verify drain: ready_i=1, valid_i=0 after one beat -> valid_o falls to 0 one cycle after consumption, data_o/sel_o unchanged.

Source files
------------

// File: rtl/channel_mux.sv
// Round-robin N:1 stream merger with a single registered output beat.
// Channel requests are granted fairly starting from the channel after the last winner.
module channel_mux #(
    parameter int DATA_WIDTH  = 4,
    parameter int SEL_WIDTH   = 3,
    parameter int INPUT_WIDTH = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [DATA_WIDTH-1:0]  data_i [INPUT_WIDTH],
    input  logic [INPUT_WIDTH-1:0] valid_i,
    output logic [INPUT_WIDTH-1:0] ready_o,
    output logic [DATA_WIDTH-1:0]  data_o,
    output logic [SEL_WIDTH-1:0]   sel_o,
    output logic                   valid_o,
    input  logic                   ready_i
);

    localparam logic [SEL_WIDTH:0]   NUM_CH  = (SEL_WIDTH+1)'(INPUT_WIDTH);
    localparam logic [SEL_WIDTH-1:0] LAST_CH = SEL_WIDTH'(INPUT_WIDTH - 1);

    logic [SEL_WIDTH-1:0] ptr;
    logic                 out_free;
    logic                 grant_any;
    logic [SEL_WIDTH-1:0] grant_idx;
    logic [SEL_WIDTH:0]   cand;
    logic                 grant_fire;

    assign out_free   = !valid_o || ready_i;
    assign grant_fire = !rst_i && out_free && grant_any;

    // Search ptr, ptr+1, ... modulo the channel count; the extra bit on cand
    // keeps the wrap arithmetic exact when ptr + offset passes INPUT_WIDTH.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < INPUT_WIDTH; i++) begin
            cand = {1'b0, ptr} + (SEL_WIDTH+1)'(i);
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            if (!grant_any && valid_i[cand[SEL_WIDTH-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[SEL_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        ready_o = '0;
        if (grant_fire) begin
            ready_o[grant_idx] = 1'b1;
        end
    end

    // A consumed beat with nothing to replace it just drops valid; data and
    // sel keep their last values so a stalled consumer sees no glitches.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            sel_o   <= '0;
            ptr     <= '0;
        end else if (grant_fire) begin
            valid_o <= 1'b1;
            data_o  <= data_i[grant_idx];
            sel_o   <= grant_idx;
            ptr     <= (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_channel_mux.sv
// Directed bench for channel_mux: stimulus pushes expected beats into a
// scoreboard queue, a negedge monitor pops them as the DUT hands beats downstream.
module tb_channel_mux;

    localparam int DW = 4;
    localparam int SW = 3;
    localparam int NW = 5;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] sel;
    } beat_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [DW-1:0] data_i [NW];
    logic [NW-1:0] valid_i = '0;
    logic [NW-1:0] ready_o;
    logic [DW-1:0] data_o;
    logic [SW-1:0] sel_o;
    logic          valid_o;
    logic          ready_i = 1'b0;

    beat_t sb[$];
    int    checks = 0;
    int    passes = 0;

    // Fixed per-channel samples; expected beats below are written from this table.
    localparam logic [DW-1:0] D0 = 4'h3, D1 = 4'h5, D2 = 4'hA, D3 = 4'hC, D4 = 4'hE;

    channel_mux #(.DATA_WIDTH(DW), .SEL_WIDTH(SW), .INPUT_WIDTH(NW)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .sel_o   (sel_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, return at the falling edge.
    task automatic applyStimulus(input logic [NW-1:0] v, input logic rdy, input logic rst);
        @(posedge clk_i);
        #1;
        valid_i = v;
        ready_i = rdy;
        rst_i   = rst;
        @(negedge clk_i);
    endtask

    task automatic expectBeat(input logic [DW-1:0] d, input logic [SW-1:0] s);
        beat_t b;
        b.data = d;
        b.sel  = s;
        sb.push_back(b);
    endtask

    // Monitor: every beat taken downstream must match the oldest expectation.
    initial begin
        beat_t exp_b;
        forever begin
            @(negedge clk_i);
            if (valid_o && ready_i && !rst_i) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_beat", {29'd0, sel_o}, 32'hFFFF_FFFF);
                end else begin
                    exp_b = sb.pop_front();
                    checkOutput("beat_data", {28'd0, data_o}, {28'd0, exp_b.data});
                    checkOutput("beat_sel", {29'd0, sel_o}, {29'd0, exp_b.sel});
                end
            end
        end
    end

    initial begin
        data_i[0] = D0;
        data_i[1] = D1;
        data_i[2] = D2;
        data_i[3] = D3;
        data_i[4] = D4;

        // Reset with every channel requesting: nothing may be granted.
        applyStimulus(5'b11111, 1'b1, 1'b1);
        checkOutput("rst_ready", {27'd0, ready_o}, 32'd0);
        checkOutput("rst_valid", {31'd0, valid_o}, 32'd0);
        checkOutput("rst_data", {28'd0, data_o}, 32'd0);
        checkOutput("rst_sel", {29'd0, sel_o}, 32'd0);

        // Single request on channel 2, then drain.
        applyStimulus(5'b00100, 1'b1, 1'b0);
        checkOutput("single_ready", {27'd0, ready_o}, 32'b00100);
        expectBeat(D2, 3'd2);
        applyStimulus(5'b00000, 1'b1, 1'b0);
        checkOutput("single_valid", {31'd0, valid_o}, 32'd1);
        checkOutput("idle_ready", {27'd0, ready_o}, 32'd0);
        applyStimulus(5'b00000, 1'b1, 1'b0);
        checkOutput("drain_valid", {31'd0, valid_o}, 32'd0);
        checkOutput("drain_data", {28'd0, data_o}, {28'd0, D2});
        checkOutput("drain_sel", {29'd0, sel_o}, 32'd2);

        // Fairness from ptr=0 with all channels requesting.
        applyStimulus(5'b00000, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(5'b11111, 1'b1, 1'b0);
            checkOutput("rr_ready", {27'd0, ready_o}, 32'd1 << (i % NW));
            if (i > 0) checkOutput("rr_valid", {31'd0, valid_o}, 32'd1);
            expectBeat(data_i[i % NW], SW'(i % NW));
        end

        // ptr=1: grant channel 1, then stall three cycles with 0 and 1 requesting.
        applyStimulus(5'b00010, 1'b1, 1'b0);
        checkOutput("bp_load_ready", {27'd0, ready_o}, 32'b00010);
        expectBeat(D1, 3'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(5'b00011, 1'b0, 1'b0);
            checkOutput("bp_ready", {27'd0, ready_o}, 32'd0);
            checkOutput("bp_valid", {31'd0, valid_o}, 32'd1);
            checkOutput("bp_data", {28'd0, data_o}, {28'd0, D1});
            checkOutput("bp_sel", {29'd0, sel_o}, 32'd1);
        end
        applyStimulus(5'b00011, 1'b1, 1'b0);
        checkOutput("bp_release_ready", {27'd0, ready_o}, 32'b00001);
        expectBeat(D0, 3'd0);

        // Grant 3 (ptr=4), then 00011 must wrap to channel 0 and then 1.
        applyStimulus(5'b01000, 1'b1, 1'b0);
        checkOutput("bp_after_sel", {29'd0, sel_o}, 32'd0);
        checkOutput("wrap_g3_ready", {27'd0, ready_o}, 32'b01000);
        expectBeat(D3, 3'd3);
        applyStimulus(5'b00011, 1'b1, 1'b0);
        checkOutput("wrap_g0_ready", {27'd0, ready_o}, 32'b00001);
        expectBeat(D0, 3'd0);
        applyStimulus(5'b00011, 1'b1, 1'b0);
        checkOutput("wrap_g1_ready", {27'd0, ready_o}, 32'b00010);
        expectBeat(D1, 3'd1);

        // Hold a channel-3 beat with ptr=4, then reset over it.
        applyStimulus(5'b01000, 1'b1, 1'b0);
        checkOutput("pre_rst_ready", {27'd0, ready_o}, 32'b01000);
        expectBeat(D3, 3'd3);
        applyStimulus(5'b11111, 1'b0, 1'b1);
        checkOutput("mid_rst_ready", {27'd0, ready_o}, 32'd0);
        checkOutput("mid_rst_sel", {29'd0, sel_o}, 32'd3);
        void'(sb.pop_back());
        applyStimulus(5'b11111, 1'b1, 1'b0);
        checkOutput("post_rst_valid", {31'd0, valid_o}, 32'd0);
        checkOutput("post_rst_data", {28'd0, data_o}, 32'd0);
        checkOutput("post_rst_sel", {29'd0, sel_o}, 32'd0);
        checkOutput("post_rst_ready", {27'd0, ready_o}, 32'b00001);
        expectBeat(D0, 3'd0);
        applyStimulus(5'b00000, 1'b1, 1'b0);
        applyStimulus(5'b00000, 1'b1, 1'b0);
        checkOutput("final_valid", {31'd0, valid_o}, 32'd0);
        checkOutput("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
